prog_tick_divider: RTL

//   Parametrised, run-time programmable tick generator; successor to the fixed 1 s divider.

---
 rtl/prog_tick_divider.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/prog_tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : prog_tick_divider
// Purpose  : Run-time programmable tick generator. It emits a 1-cycle tick every
//            div_cur clocks in continuous or one-shot mode. A new divisor is
//            taken through a valid/ready handshake.
// Options  : define TICKDIV_SQUARE_EN to enable the sq_out toggle flop.
// Revision : 1.0  initial release
// ============================================================================
module prog_tick_divider #(
   parameter int unsigned     WIDTH       = 32,
   parameter longint unsigned DEFAULT_DIV = 64'd100000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             oneshot,
   input  logic             div_valid,
   input  logic [WIDTH-1:0] div_value,
   output logic             div_ready,
   output logic             tick,
   output logic             busy,
   output logic             sq_out
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_default_div =
      (DEFAULT_DIV == 64'd0) ? c_one : WIDTH'(DEFAULT_DIV);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div_cur;
   logic [WIDTH-1:0] r_div_pend;
   logic             r_ready;
   logic             r_mode_os;
   logic             r_tick;
   logic             r_busy;

   logic             w_last;
   logic             w_period_end;
   logic             w_pending;
   logic             w_accept;
   logic             w_copy;
   logic [WIDTH-1:0] w_value;

   assign w_last       = (r_cnt == (r_div_cur - c_one));
   assign w_period_end = (r_state == S_RUN) && en && w_last;
   assign w_pending    = ~r_ready;
   assign w_accept     = div_valid && r_ready;
   assign w_value      = (div_value == '0) ? c_one : div_value;
   // A pending divisor only lands on a period boundary while running, so the
   // period in flight always completes with the divisor it started with.
   assign w_copy       = w_pending && ((r_state != S_RUN) || w_period_end);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (en) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!en) begin
               w_state_nxt = S_IDLE;
            end else if (w_last && r_mode_os) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (!en) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_mode_os <= 1'b0;
         r_tick    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_period_end;
         r_busy  <= (w_state_nxt == S_RUN);
         if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
            r_cnt <= w_last ? '0 : (r_cnt + c_one);
         end else begin
            r_cnt <= '0;
         end
         if ((r_state == S_IDLE) && en) begin
            r_mode_os <= oneshot;
         end
      end
   end

   // Accept and copy are mutually exclusive: accept needs ready, copy needs pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cur  <= c_default_div;
         r_div_pend <= c_default_div;
         r_ready    <= 1'b1;
      end else if (w_copy) begin
         r_div_cur <= r_div_pend;
         r_ready   <= 1'b1;
      end else if (w_accept) begin
         r_div_pend <= w_value;
         r_ready    <= 1'b0;
      end
   end

`ifdef TICKDIV_SQUARE_EN
   logic r_sq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sq <= 1'b0;
      end else if (w_state_nxt == S_IDLE) begin
         r_sq <= 1'b0;
      end else if (w_period_end) begin
         r_sq <= ~r_sq;
      end
   end

   assign sq_out = r_sq;
`else
   assign sq_out = 1'b0;
`endif

   assign div_ready = r_ready;
   assign tick      = r_tick;
   assign busy      = r_busy;

endmodule
`default_nettype wire
